// File: rtl/rr_arbiter_8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter_8_pkg                                       |
// | Description : Shared sizes and state encodings for the 8-way         |
// |               round-robin arbiter.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;  // number of requesters
  localparam int ID_W  = 3;  // width of a requester index
  localparam int CNT_W = 8;  // width of the grant hold counter

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_8_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : prio_enc_8to3_v                                        |
// | Description : Combinational 8-to-3 priority encoder, lowest index    |
// |               wins, with a valid flag for a non-zero input.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module prio_enc_8to3_v
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] in_vec,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last write and wins.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        idx = ID_W'(i);
      end
    end
  end

  assign valid = |in_vec;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter_8                                           |
// | Description : Eight-way round-robin arbiter with hold-until-release  |
// |               grants, back-to-back handoff and a hold-time limit.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16  // 1..255 cycles; 0 disables the limit
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;

  logic [ID_W-1:0]    search_start;
  logic [2*N_REQ-1:0] req_rot_wide;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W-1:0]    enc_idx;
  logic               enc_valid;
  logic [ID_W-1:0]    winner;
  logic               hold_hit;
  logic               release_evt;

  // While busy the only arbitration that matters is the handoff, which
  // starts just past the current owner; when idle it starts at the pointer.
  assign search_start = (state_q == BUSY) ? gnt_id_q + ID_W'(1) : ptr_q;

  // Rotate right so the search start lands on bit 0 of the encoder input.
  assign req_rot_wide = {req, req} >> search_start;
  assign req_rot      = req_rot_wide[N_REQ-1:0];

  prio_enc_8to3_v u_prio_enc (
    .in_vec (req_rot),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  // Undo the rotation; 3-bit wrap gives the mod-8 add for free.
  assign winner      = enc_idx + search_start;
  assign hold_hit    = HOLD_EN && (hold_cnt_q == HOLD_LAST);
  assign release_evt = done || !req[gnt_id_q] || hold_hit;

  // Next-state, pointer, hold counter and registered-output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d     = BUSY;
          gnt_d       = ONE_HOT0 << winner;
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (release_evt) begin
          ptr_d      = gnt_id_q + ID_W'(1);
          // A simultaneous done is a normal completion, not a revocation.
          timeout_d  = hold_hit && !done;
          hold_cnt_d = '0;
          if (enc_valid) begin
            gnt_d       = ONE_HOT0 << winner;
            gnt_id_d    = winner;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rr_arbiter_8                                        |
// | Description : Self-checking bench for rr_arbiter_8: directed vector  |
// |               table, asynchronous reset sequence and a randomised    |
// |               phase against a behavioural model.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
    logic       pchk;
    logic [2:0] ptr;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // behavioural model state
  logic       m_busy;
  logic [2:0] m_id;
  logic [2:0] m_ptr;
  int         m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g,
                     input logic [2:0] id, input logic to,
                     input logic pchk = 1'b0, input logic [2:0] p = 3'd0);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.id = id; v.to = to; v.pchk = pchk; v.ptr = p;
    vecs.push_back(v);
  endtask

  // Called at a falling edge: drive, queue the expectation, compare after the next rising edge.
  task automatic apply(input logic [7:0] r, input logic d, input exp_t e, input string tag);
    exp_t got;
    req  = r;
    done = d;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    check({tag, ".gnt"},       32'(gnt),       32'(got.gnt));
    check({tag, ".gnt_id"},    32'(gnt_id),    32'(got.id));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(got.valid));
    check({tag, ".timeout"},   32'(timeout),   32'(got.to));
  endtask

  // Search-order model: walk start..start+7 looking for the first requester.
  task automatic model_step(input logic [7:0] r, input logic d, output exp_t e);
    logic [2:0] start;
    logic [2:0] idx;
    logic       limit;
    logic       found;
    e.to  = 1'b0;
    limit = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD - 1);
    if (!m_busy || d || !r[m_id] || limit) begin
      start = m_busy ? m_id + 3'd1 : m_ptr;
      if (m_busy) begin
        e.to  = limit && !d;
        m_ptr = m_id + 3'd1;
      end
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = start + 3'(k);
        if (!found && r[idx]) begin
          found = 1'b1;
          m_id  = idx;
        end
      end
      m_busy = found;
      m_cnt  = 0;
      if (!found) m_id = 3'd0;
    end else if (m_cnt < 255) begin
      m_cnt++;
    end
    e.gnt   = m_busy ? (8'h01 << m_id) : 8'h00;
    e.id    = m_id;
    e.valid = m_busy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [7:0] r;
    logic       d;

    // idle, with a stray done
    for (int i = 0; i < 5; i++) add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    // two requesters alternating on done
    add(8'h81, 1'b0, 8'h01, 3'd0, 1'b0);
    add(8'h81, 1'b1, 8'h80, 3'd7, 1'b0);
    add(8'h81, 1'b1, 8'h01, 3'd0, 1'b0);
    add(8'h81, 1'b1, 8'h80, 3'd7, 1'b0);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0);
    // all requesting, done every third cycle
    for (int g = 0; g < 9; g++)
      for (int c = 0; c < 3; c++)
        add(8'hFF, (g > 0 && c == 0), 8'h01 << (g % 8), 3'(g % 8), 1'b0);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd1);
    // sole requester hitting the hold limit twice
    for (int i = 0; i < 4; i++) add(8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
    add(8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++) add(8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
    add(8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd3);
    // owner drops its request; then done coincides with the hold limit
    add(8'h28, 1'b0, 8'h08, 3'd3, 1'b0);
    add(8'h20, 1'b0, 8'h20, 3'd5, 1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 3; i++) add(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    add(8'h20, 1'b1, 8'h20, 3'd5, 1'b0, 1'b1, 3'd6);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // reset state
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #12;
    check("reset.gnt",       32'(gnt),       32'h00);
    check("reset.gnt_id",    32'(gnt_id),    32'h0);
    check("reset.gnt_valid", 32'(gnt_valid), 32'h0);
    check("reset.timeout",   32'(timeout),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      e.gnt   = vecs[i].gnt;
      e.id    = vecs[i].id;
      e.valid = (vecs[i].gnt != 8'h00);
      e.to    = vecs[i].to;
      apply(vecs[i].req, vecs[i].done, e, $sformatf("vec%0d", i));
      if (vecs[i].pchk) check($sformatf("vec%0d.ptr", i), 32'(dut.ptr_q), 32'(vecs[i].ptr));
    end

    // asynchronous reset in the middle of a grant
    req  = 8'hFF;
    done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset.gnt_valid", 32'(gnt_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset.gnt",       32'(gnt),       32'h00);
    check("async_reset.gnt_id",    32'(gnt_id),    32'h0);
    check("async_reset.gnt_valid", 32'(gnt_valid), 32'h0);
    check("async_reset.timeout",   32'(timeout),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // first grant after reset must start from requester 0
    m_busy = 1'b0; m_id = 3'd0; m_ptr = 3'd0; m_cnt = 0;
    e.gnt = 8'h01; e.id = 3'd0; e.valid = 1'b1; e.to = 1'b0;
    model_step(8'hFF, 1'b0, e);
    apply(8'hFF, 1'b0, e, "post_reset");
    check("post_reset.first_id", 32'(gnt_id), 32'h0);

    // randomised traffic against the model
    r = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) r = 8'h00;
      d = ($urandom_range(0, 4) == 0);
      model_step(r, d, e);
      apply(r, d, e, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among eight requesters. It is built around an 8-to-3 priority encoder. A rotating priority pointer ensures every active requester is served within eight grants. Grants are held until the owner signals completion, drops its request, or exceeds a hold-time limit. The block sits between request sources and the shared datapath and drives that datapath's select and enable.

## Interface
- MAX_HOLD, 16: maximum cycles a grant may be held; range 1..255; 0 disables the timeout.
- clk  input  1  rising-edge clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i; level-sensitive.
- done  input  1  one-cycle pulse from the current owner: transfer finished, release the grant.
- gnt  output  8  one-hot grant vector, registered; all-zero when idle.
- gnt_id  output  3  binary index of the granted requester, registered.
- gnt_valid  output  1  high while a grant is held; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- States: IDLE (no owner) and BUSY (owner = gnt_id).
- Pointer ptr[2:0] holds the highest-priority index. Search order is ptr, ptr+1, …, ptr+7, all mod 8.
- Winner: first set bit of req in search order. Implement by rotating req right by ptr, priority-encoding the lowest set bit, then adding ptr mod 8.
- IDLE, req != 0: load gnt/gnt_id with the winner, gnt_valid=1, hold_cnt=0, go to BUSY.
- IDLE, req == 0: remain in IDLE; outputs stay at zero.
- BUSY, release event: done=1, or req[gnt_id]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - ptr <= gnt_id+1 mod 8.
  - Re-arbitrate in the same cycle with the updated search start (gnt_id+1), so grants go back-to-back with no idle gap.
  - The releasing requester is eligible again only if it still requests. It is searched last, so when it is the sole requester it is re-granted.
  - If no eligible request remains, go to IDLE with outputs zeroed.
- BUSY, no release: hold the grant and increment hold_cnt (8-bit, saturating).
- timeout is asserted for exactly the cycle in which the hold limit causes the release. If done is also high in that cycle, done takes precedence and timeout stays 0.
- done while in IDLE is ignored.
- Requests from non-owners never pre-empt the current owner.

## Timing
- Reset values: gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state IDLE.
- Reset is asynchronous: asserting rst_n mid-grant clears all outputs immediately, without waiting for a clock edge.
- Latency: req seen at edge k gives gnt valid after edge k (one cycle).
- Release handoff: done sampled at edge k gives the new owner's gnt after edge k. The old grant is never visible together with the new one.
- Timeout: a grant first presented after edge k is revoked at edge k+MAX_HOLD. The owner therefore holds the resource for exactly MAX_HOLD cycles.
- No combinational path from req or done to any output.

## Structure
- Shared package holds N_REQ=8, ID_W=3, CNT_W=8 and the state encodings IDLE=1'b0, BUSY=1'b1.
- One sub-module: prio_enc_8to3_v, a combinational 8-to-3 priority encoder (lowest index wins) with a valid output. Instantiate it once on the rotated request vector.
- Top module contains the rotator, the pointer, hold_cnt, the FSM and the output registers.

## Test plan
- Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- req=8'b1000_0001 from reset, pulse done after each grant -> grant order id 0, 7, 0, 7; each handoff has no idle cycle.
- req=8'hFF held, done pulsed every 3 cycles -> gnt_id sequence 0,1,2,…,7,0; each grant lasts exactly 3 cycles.
- MAX_HOLD=4, req=8'b0000_0100 held and done never asserted -> gnt_id=2 for 4 cycles, then timeout=1 for one cycle, then id 2 is re-granted (sole requester).
- Owner id 3 drops req[3] while req[5]=1 -> the next cycle gives gnt=8'b0010_0000 and ptr=4; with MAX_HOLD=4, assert done in the same cycle as the timeout edge -> timeout stays 0.
- Assert rst_n=0 asynchronously mid-grant with req=8'hFF -> outputs clear before the next clk edge. After release, the first grant is id 0.
